// File: rtl/branch_resolve.sv
// branch_resolve: queues fetch-stage branch predictions in program order and
// resolves the oldest one against the execute outcome. Drives the predictor
// update, a one-cycle redirect on mispredict, and saturating statistics.
module branch_resolve #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pred_valid,
    output logic            pred_ready,
    input  logic [PC_W-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic            res_valid,
    input  logic            res_taken,
    input  logic [PC_W-1:0] res_target,
    input  logic            flush,
    output logic            upd_valid,
    output logic            upd_taken,
    output logic [PC_W-1:0] upd_pc,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            empty,
    output logic            underflow,
    output logic [15:0]     br_cnt,
    output logic [15:0]     miss_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STAT_W = 16;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_t;

    pred_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;

    pred_t              head_c;
    logic               pop_c, mispred_c, push_c, clear_c, underflow_set_c;
    logic [PC_W-1:0]    correct_pc_c;

    assign empty      = (count_q == '0);
    assign pred_ready = (count_q != CNT_W'(DEPTH));

    // Pop/push decisions and mispredict detection for this cycle
    always_comb begin
        head_c          = mem_q[head_q];
        pop_c           = 1'b0;
        mispred_c       = 1'b0;
        push_c          = 1'b0;
        clear_c         = 1'b0;
        underflow_set_c = 1'b0;
        correct_pc_c    = res_taken ? res_target : head_c.pc + PC_W'(4);

        if (flush) begin
            clear_c = 1'b1;
        end else begin
            pop_c           = res_valid && !empty;
            underflow_set_c = res_valid && empty;
            mispred_c       = pop_c && ((head_c.taken != res_taken) ||
                                        (res_taken && head_c.target != res_target));
            clear_c         = mispred_c;
            push_c          = pred_valid && pred_ready && !mispred_c;
        end
    end

    // Queue storage; written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[tail_q] <= '{pc: pred_pc, taken: pred_taken, target: pred_target};
        end
    end

    // Queue pointers and occupancy; mispredict and flush empty the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear_c) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_c)  head_q <= head_q + PTR_W'(1);
            if (push_c) tail_q <= tail_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Registered predictor update, redirect and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid   <= 1'b0;
            upd_taken   <= 1'b0;
            upd_pc      <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            underflow   <= 1'b0;
            br_cnt      <= '0;
            miss_cnt    <= '0;
        end else begin
            upd_valid <= pop_c;
            redirect  <= mispred_c;
            if (pop_c) begin
                upd_taken <= res_taken;
                upd_pc    <= head_c.pc;
                if (br_cnt != {STAT_W{1'b1}}) br_cnt <= br_cnt + STAT_W'(1);
            end
            if (mispred_c) begin
                redirect_pc <= correct_pc_c;
                if (miss_cnt != {STAT_W{1'b1}}) miss_cnt <= miss_cnt + STAT_W'(1);
            end
            if (underflow_set_c) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: stimulus pushes expected updates,
// a negedge monitor pops and compares whenever upd_valid is presented.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic        pred_ready;
    logic [31:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        flush = 1'b0;
    logic        upd_valid, upd_taken, redirect, empty, underflow;
    logic [31:0] upd_pc, redirect_pc;
    logic [15:0] br_cnt, miss_cnt;

    branch_resolve #(.DEPTH(4), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .flush(flush),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .empty(empty), .underflow(underflow), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: every update pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_upd: got upd_pc %0h expected no update", upd_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("upd_pc", upd_pc, mon_e.pc);
                    chk("upd_taken", 32'(upd_taken), 32'(mon_e.taken));
                    chk("redirect", 32'(redirect), 32'(mon_e.redir));
                    if (mon_e.redir) chk("redirect_pc", redirect_pc, mon_e.rpc);
                end
            end else if (redirect) begin
                n_checks++;
                $display("FAIL stray_redirect: got redirect 1 expected 0 (pc %0h)", redirect_pc);
            end
        end
    end

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptg, input logic rv, input logic rt,
                         input logic [31:0] rtg, input logic fl);
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg; flush = fl;
        @(posedge clk); #1;
        pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        drive(1'b1, pc, t, tg, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic t, input logic r,
                              input logic [31:0] rpc);
        exp_t e;
        e.pc = pc; e.taken = t; e.redir = r; e.rpc = rpc;
        sb.push_back(e);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        drive(1'b0, '0, 1'b0, '0, 1'b1, t, tg, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(pred_ready), 32'd1);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_br_cnt", 32'(br_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three not-taken branches resolved in order
        push(32'h1000, 1'b0, '0);
        push(32'h1010, 1'b0, '0);
        push(32'h1020, 1'b0, '0);
        chk("q3_empty", 32'(empty), 32'd0);
        expect_upd(32'h1000, 1'b0, 1'b0, '0); resolve(1'b0, '0);
        expect_upd(32'h1010, 1'b0, 1'b0, '0); resolve(1'b0, '0);
        expect_upd(32'h1020, 1'b0, 1'b0, '0); resolve(1'b0, '0);
        chk("q3_br_cnt", 32'(br_cnt), 32'd3);
        chk("q3_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("q3_empty_after", 32'(empty), 32'd1);

        // Fill to DEPTH, fifth push dropped, drain with pointer wrap
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 16), 1'b0, '0);
        chk("full_ready", 32'(pred_ready), 32'd0);
        push(32'h140, 1'b0, '0);
        chk("full_ready2", 32'(pred_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_upd(32'h100 + 32'(i * 16), 1'b0, 1'b0, '0);
            resolve(1'b0, '0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_br_cnt", 32'(br_cnt), 32'd7);
        push(32'h200, 1'b0, '0);
        expect_upd(32'h200, 1'b0, 1'b0, '0);
        drive(1'b1, 32'h210, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("pushpop_empty", 32'(empty), 32'd0);
        expect_upd(32'h210, 1'b0, 1'b0, '0); resolve(1'b0, '0);
        chk("pushpop_empty2", 32'(empty), 32'd1);

        // Direction mispredict with same-cycle push dropped
        push(32'h2000, 1'b0, '0);
        expect_upd(32'h2000, 1'b1, 1'b1, 32'h3000);
        drive(1'b1, 32'h2100, 1'b0, '0, 1'b1, 1'b1, 32'h3000, 1'b0);
        chk("mp_empty", 32'(empty), 32'd1);
        chk("mp_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("mp_br_cnt", 32'(br_cnt), 32'd10);

        // Target mispredict, taken->not-taken, correct taken, pc+4 wrap
        push(32'h3800, 1'b1, 32'h4000);
        expect_upd(32'h3800, 1'b1, 1'b1, 32'h4800); resolve(1'b1, 32'h4800);
        push(32'h5000, 1'b1, 32'h6000);
        expect_upd(32'h5000, 1'b0, 1'b1, 32'h5004); resolve(1'b0, '0);
        push(32'h7000, 1'b1, 32'h7100);
        expect_upd(32'h7000, 1'b1, 1'b0, '0); resolve(1'b1, 32'h7100);
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        expect_upd(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0); resolve(1'b0, '0);
        chk("mix_miss_cnt", 32'(miss_cnt), 32'd4);
        chk("mix_br_cnt", 32'(br_cnt), 32'd14);

        // Underflow: resolve on empty, same-cycle push still lands
        chk("pre_underflow", 32'(underflow), 32'd0);
        drive(1'b1, 32'h8000, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("underflow_set", 32'(underflow), 32'd1);
        chk("underflow_push", 32'(empty), 32'd0);
        chk("underflow_br_cnt", 32'(br_cnt), 32'd14);
        expect_upd(32'h8000, 1'b0, 1'b0, '0); resolve(1'b0, '0);
        chk("underflow_sticky", 32'(underflow), 32'd1);

        // Flush beats resolve and push
        push(32'h9000, 1'b0, '0);
        push(32'h9010, 1'b0, '0);
        drive(1'b1, 32'h9020, 1'b0, '0, 1'b1, 1'b1, 32'hA000, 1'b1);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_br_cnt", 32'(br_cnt), 32'd15);
        chk("flush_miss_cnt", 32'(miss_cnt), 32'd4);
        @(posedge clk); #1;
        chk("flush_empty2", 32'(empty), 32'd1);

        // Asynchronous reset mid-traffic while an update pulse is live
        push(32'hA000, 1'b0, '0);
        push(32'hA010, 1'b0, '0);
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b0;
        @(posedge clk); #1;
        res_valid = 1'b0;
        chk("pre_arst_upd", 32'(upd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_upd_valid", 32'(upd_valid), 32'd0);
        chk("arst_upd_pc", upd_pc, 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        chk("arst_br_cnt", 32'(br_cnt), 32'd0);
        chk("arst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("arst_underflow", 32'(underflow), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ready", 32'(pred_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stream resolves until br_cnt saturates
        push(32'h0, 1'b0, '0);
        for (int i = 0; i < 65535; i++) begin
            expect_upd(32'(i * 4), 1'b0, 1'b0, '0);
            drive(1'b1, 32'((i + 1) * 4), 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        chk("sat_reach", 32'(br_cnt), 32'hFFFF);
        expect_upd(32'(65535 * 4), 1'b0, 1'b0, '0);
        drive(1'b1, 32'(65536 * 4), 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        expect_upd(32'(65536 * 4), 1'b0, 1'b0, '0);
        resolve(1'b0, '0);
        chk("sat_hold", 32'(br_cnt), 32'hFFFF);
        chk("sat_empty", 32'(empty), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-side resolution unit for the fetch-stage 2-bit branch predictor. It queues every prediction issued at fetch in program order and compares the oldest entry against the actual outcome when execute resolves the branch. It then drives the predictor update (is_branch/branch) and, on a mispredict, a one-cycle redirect with the correct PC plus a queue flush. It also keeps saturating branch and mispredict statistics counters.

## Interface
- DEPTH, 4, in-flight prediction queue entries; power of two, ≥2
- PC_W, 32, PC/target width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pred_valid  in  1  fetch pushes a prediction record this cycle
- pred_ready  out  1  queue not full (combinational from count)
- pred_pc  in  PC_W  PC of predicted branch
- pred_taken  in  1  predicted direction
- pred_target  in  PC_W  predicted target (don't-care if not taken)
- res_valid  in  1  execute resolves the oldest queued branch this cycle
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual target
- flush  in  1  external pipeline flush (exception/ertn); discards all entries
- upd_valid  out  1  registered pulse: predictor update (drives is_branch)
- upd_taken  out  1  registered: actual direction (drives branch)
- upd_pc  out  PC_W  registered: PC of resolved branch
- redirect  out  1  registered pulse: mispredict, refetch
- redirect_pc  out  PC_W  registered: correct next PC
- empty  out  1  queue count == 0
- underflow  out  1  sticky: res_valid seen with empty queue
- br_cnt  out  16  saturating count of resolved branches
- miss_cnt  out  16  saturating count of mispredicts

## Operation
- Queue: circular buffer, head/tail pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Push accepted when pred_valid && pred_ready; pred_ready = (count != DEPTH), independent of same-cycle pop. Push while full is ignored (no entry, no error).
- Pop when res_valid && !empty: head entry compared with outcome.
- Mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
- Correct PC = res_taken ? res_target : head.pc + 4 (modulo 2^PC_W, wraps).
- Every valid pop: upd_valid=1, upd_taken=res_taken, upd_pc=head.pc next cycle; br_cnt+1 (saturates at 16'hFFFF).
- Mispredict pop: additionally redirect=1, redirect_pc=correct PC next cycle; miss_cnt+1 (saturating); entire queue cleared (count=0, head=tail=0); a push in the same cycle is dropped.
- Correct pop with simultaneous push: both take effect, count unchanged.
- res_valid with empty queue: no pop, no update, underflow set to 1 and held until reset; a same-cycle push still lands.
- flush: clears queue same edge, drops same-cycle push, suppresses any same-cycle pop (no upd_valid, no redirect, counters unchanged). flush has priority over res_valid.
- No state machine beyond queue occupancy; underflow is the only sticky flag.

## Timing
- Reset (rst_n=0, async): count=0, head=tail=0, upd_valid=0, upd_taken=0, upd_pc=0, redirect=0, redirect_pc=0, underflow=0, br_cnt=0, miss_cnt=0; empty=1, pred_ready=1. Reset mid-operation discards all entries immediately.
- Latency res_valid → upd_valid/redirect: 1 cycle; both are single-cycle pulses unless res_valid repeats.
- Push at edge N visible for pop from cycle N+1; same-cycle push-to-empty plus res_valid does not resolve the new entry.
- Back-to-back pops at 1/cycle supported; after a mispredict the queue is empty at N+1, so a res_valid at N+1 sets underflow.
- pred_ready and empty are combinational from registered count; no input→output combinational path.

## Test plan
- Reset then push 3 entries (pc 0x1000/0x1010/0x1020, taken=0), resolve all not-taken → 3 upd_valid pulses with upd_pc in order, redirect never, br_cnt=3, miss_cnt=0, empty=1.
- Fill DEPTH=4, pred_ready=0, 5th push dropped; resolve 4 → exactly 4 updates, pointers wrap, subsequent push/pop correct.
- Entry pc 0x2000 predicted not-taken, res_taken=1 target 0x3000 → next cycle redirect=1, redirect_pc=0x3000, miss_cnt=1, queue empty; same-cycle push dropped.
- Predicted taken target 0x4000, actual taken target 0x4800 → redirect_pc=0x4800; predicted taken, actual not-taken at pc 0x5000 → redirect_pc=0x5004.
- res_valid on empty → underflow=1, no upd_valid; stays 1 after further traffic until rst_n low.
- flush asserted with res_valid and pred_valid on 2-entry queue → no upd_valid/redirect, counters unchanged, empty=1; rst_n low mid-traffic asynchronously clears all outputs; preload br_cnt near 16'hFFFF and confirm saturation.
